fetch_stall_controller: RTL
===========================

Name: fetch_stall_controller

Overview:
Sequences the fetch stage and the F->D pipeline register around a variable-latency instruction memory. Generates StallF, StallD and the decode-register clear (FlushD), and issues/tracks instruction-memory requests. Remembers a branch/jump redirect raised during a stall, so the wrong-path instruction is flushed when the stall releases. Sits between the PC/fetch logic, the F->D pipeline register and the hazard unit.

Parameters:
- TIMEOUT, 64: maximum number of consecutive WAIT cycles before imem_timeout is raised.
- CNT_W, 7: width of the wait-cycle counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- imem_ready  in  1  instruction word valid this cycle for the outstanding request.
- hazard_stall_D  in  1  load-use/branch-operand stall from the hazard unit.
- pc_src_D  in  1  branch taken or jump resolved in decode; PC redirects this cycle.
- imem_req  out  1  request instruction at the current PC.
- StallF  out  1  hold the PC register.
- StallD  out  1  hold the F->D register.
- FlushD  out  1  clear the F->D register (bubble).
- redirect_pending  out  1  a redirect is latched and not yet flushed.
- imem_timeout  out  1  sticky error flag; the wait exceeded TIMEOUT.

Behaviour:
- Reset (async) values:
  - state=IDLE, pending=0, wait_cnt=0, imem_timeout=0.
  - Outputs: imem_req=0, StallF=1, StallD=1, FlushD=0.
- States:
  - IDLE: one cycle after reset deasserts, then goes to FETCH. Drives imem_req=0 and StallF=StallD=1.
  - FETCH: imem_req=1.
    - imem_ready=1: instruction accepted. StallF=StallD=hazard_stall_D. Stays in FETCH.
    - imem_ready=0: StallF=StallD=1. Goes to WAIT.
  - WAIT: imem_req=1, StallF=StallD=1, wait_cnt increments each cycle.
    - imem_ready=1 and pending=0: goes to FETCH; this cycle's stalls = hazard_stall_D.
    - imem_ready=1 and pending=1: goes to DISCARD.
  - DISCARD: the word returned in WAIT is wrong-path.
    - For one cycle: FlushD=1, StallF=0, StallD=0, pending cleared. Then goes to FETCH.
- Redirect tracking:
  - pending is set when pc_src_D=1 and StallD=1 in the same cycle.
  - pending is cleared on the cycle FlushD is issued.
- FlushD = (pc_src_D | pending) & ~StallD. This is combinational from registered state and the inputs.
- Simultaneous events:
  - pc_src_D=1 with hazard_stall_D=1 in FETCH sets pending; no flush yet.
  - A flush is issued on the first unstalled cycle.
- wait_cnt:
  - Clears on leaving WAIT.
  - Saturates at 2^CNT_W-1.
  - imem_timeout sets when wait_cnt reaches TIMEOUT. It stays set until reset. The FSM keeps waiting; there is no recovery.
- Latency: a miss answered after N wait cycles holds StallF/StallD high for exactly N+1 cycles.
- An asserted reset overrides every state immediately, including mid-WAIT or DISCARD. The pending redirect is lost; the PC is reset by its own logic.

Optional Feature:
- Macro: FETCH_STALL_PERF_EN.
- With the macro defined:
  - Adds 32-bit outputs stall_cycles and flush_count. Both reset to 0 and wrap modulo 2^32.
  - stall_cycles increments on each cycle with StallD=1 outside IDLE.
  - flush_count increments on each cycle with FlushD=1.
- Without the macro: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package/header, include-guarded:
  - 2-bit state encodings FS_IDLE=0, FS_FETCH=1, FS_WAIT=2, FS_DISCARD=3.
  - Default TIMEOUT constant.
- One natural sub-module, wait_timer: the saturating counter plus the sticky timeout flag, with inputs clock, reset, enable, clear.

Test Plan:
- Reset, then imem_ready=1 held:
  - Cycle 0 after reset: IDLE, StallF=StallD=1, imem_req=0.
  - Cycle 1: FETCH, stalls=0, imem_req=1.
- Miss: imem_ready low for 3 cycles, then high.
  - StallF=StallD=1 for exactly 4 cycles.
  - Back in FETCH; FlushD never asserted.
- Redirect during a miss: pc_src_D=1 on the first WAIT cycle, imem_ready returns 2 cycles later.
  - redirect_pending=1 until DISCARD.
  - In DISCARD: FlushD=1, stalls=0, for one cycle.
  - Then pending=0.
- Load-use plus redirect: hazard_stall_D=1 and pc_src_D=1 together, hazard drops next cycle.
  - No flush while stalled.
  - FlushD=1 on the release cycle.
- Timeout: TIMEOUT=4, imem_ready held low for 10 cycles.
  - imem_timeout rises on the 4th WAIT cycle and stays set after the memory responds.
- Async reset mid-WAIT with pending=1: all outputs return to reset values immediately, without a clock edge.

Source files
------------

// File: rtl/fetch_stall_controller_pkg.sv
// Shared types and defaults for the fetch stall controller.
// The FETCH_STALL_PERF_EN macro enables the optional performance counters in the top.
`ifndef FETCH_STALL_CONTROLLER_PKG_SV
`define FETCH_STALL_CONTROLLER_PKG_SV

package fetch_stall_controller_pkg;

    typedef enum logic [1:0] {
        FS_IDLE    = 2'd0,
        FS_FETCH   = 2'd1,
        FS_WAIT    = 2'd2,
        FS_DISCARD = 2'd3
    } fs_state_e;

    localparam int DEFAULT_TIMEOUT = 64;
    localparam int DEFAULT_CNT_W   = 7;

endpackage

`endif

// File: rtl/fetch_stall_controller_wait_timer.sv
// Saturating wait-cycle counter with a sticky timeout flag.
// The flag rises on the edge where the count reaches TIMEOUT and holds until reset.
module fetch_stall_controller_wait_timer
    import fetch_stall_controller_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int CNT_W   = DEFAULT_CNT_W
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic timeout
);

    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic             timeout_r;
    logic             timeout_next_s;

    // Next count (clear wins, saturate at all-ones) and next sticky flag
    always_comb begin
        cnt_next_s     = cnt_r;
        timeout_next_s = timeout_r;
        if (clear) begin
            cnt_next_s = '0;
        end else if (enable && (cnt_r != CNT_MAX)) begin
            cnt_next_s = cnt_r + CNT_ONE;
        end else begin
            cnt_next_s = cnt_r;
        end
        if (enable && !clear && (cnt_next_s >= CNT_LIMIT)) begin
            timeout_next_s = 1'b1;
        end else begin
            timeout_next_s = timeout_r;
        end
    end

    // Counter and flag registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_r     <= '0;
            timeout_r <= 1'b0;
        end else begin
            cnt_r     <= cnt_next_s;
            timeout_r <= timeout_next_s;
        end
    end

    assign timeout = timeout_r;

endmodule

// File: rtl/fetch_stall_controller.sv
// Fetch/F->D stall sequencing around a variable-latency instruction memory.
// Optional macro FETCH_STALL_PERF_EN adds stall_cycles and flush_count outputs.
module fetch_stall_controller
    import fetch_stall_controller_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int CNT_W   = DEFAULT_CNT_W
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        imem_ready,
    input  logic        hazard_stall_D,
    input  logic        pc_src_D,
    output logic        imem_req,
    output logic        StallF,
    output logic        StallD,
    output logic        FlushD,
    output logic        redirect_pending,
    output logic        imem_timeout
`ifdef FETCH_STALL_PERF_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
`endif
);

    fs_state_e state_r;
    fs_state_e next_state_s;
    logic      pending_r;
    logic      pending_next_s;
    logic      req_s;
    logic      stall_s;
    logic      flush_s;
    logic      wait_en_s;

    // Request/stall decode and next state; outputs follow the inputs within the cycle
    always_comb begin
        next_state_s = state_r;
        req_s        = 1'b0;
        stall_s      = 1'b1;
        case (state_r)
            FS_IDLE: begin
                next_state_s = FS_FETCH;
            end
            FS_FETCH: begin
                req_s = 1'b1;
                if (imem_ready) begin
                    stall_s = hazard_stall_D;
                end else begin
                    stall_s      = 1'b1;
                    next_state_s = FS_WAIT;
                end
            end
            FS_WAIT: begin
                req_s = 1'b1;
                if (imem_ready && !pending_r) begin
                    stall_s      = hazard_stall_D;
                    next_state_s = FS_FETCH;
                end else if (imem_ready) begin
                    // Word fetched before the redirect is wrong-path: drop it next cycle
                    stall_s      = 1'b1;
                    next_state_s = FS_DISCARD;
                end else begin
                    stall_s = 1'b1;
                end
            end
            FS_DISCARD: begin
                stall_s      = 1'b0;
                next_state_s = FS_FETCH;
            end
            default: begin
                next_state_s = FS_IDLE;
            end
        endcase
        flush_s = (pc_src_D | pending_r) & ~stall_s;
    end

    // Redirect latch: set while stalled, cleared by the flush it causes
    always_comb begin
        if (flush_s) begin
            pending_next_s = 1'b0;
        end else if (pc_src_D && stall_s) begin
            pending_next_s = 1'b1;
        end else begin
            pending_next_s = pending_r;
        end
    end

    // FSM state and pending redirect registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r   <= FS_IDLE;
            pending_r <= 1'b0;
        end else begin
            state_r   <= next_state_s;
            pending_r <= pending_next_s;
        end
    end

    assign wait_en_s = (state_r == FS_WAIT) && !imem_ready;

    fetch_stall_controller_wait_timer #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_wait_timer (
        .clock   (clock),
        .reset   (reset),
        .enable  (wait_en_s),
        .clear   (!wait_en_s),
        .timeout (imem_timeout)
    );

    assign imem_req         = req_s;
    assign StallF           = stall_s;
    assign StallD           = stall_s;
    assign FlushD           = flush_s;
    assign redirect_pending = pending_r;

`ifdef FETCH_STALL_PERF_EN
    logic [31:0] stall_cycles_r;
    logic [31:0] flush_count_r;

    // Free-running performance counters, wrapping at 2^32
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cycles_r <= 32'd0;
            flush_count_r  <= 32'd0;
        end else begin
            if (stall_s && (state_r != FS_IDLE)) begin
                stall_cycles_r <= stall_cycles_r + 32'd1;
            end
            if (flush_s) begin
                flush_count_r <= flush_count_r + 32'd1;
            end
        end
    end

    assign stall_cycles = stall_cycles_r;
    assign flush_count  = flush_count_r;
`endif

endmodule
